// File: rtl/uart_pkg.sv
// Shared definitions for the 11-bit UART frame (start, 8 data LSB-first, parity, stop).
// Contents: frame sizes, line levels, tx FSM state encoding, parity helper.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 11;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // Transmitter states: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Even parity is the XOR of the data bits; odd parity is its complement.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] b, input logic odd);
    return odd ? ~^b : ^b;
  endfunction

endpackage

// File: rtl/uart_tx_completa_baud_tick.sv
// Bit-time counter for the UART transmitter.
// Ports: clk, reset (sync, active-high), clr (restart at frame accept),
//        en (count while a frame is in flight), tick_c (terminal count),
//        pre_tick_c (one cycle before terminal count).
module baud_tick_tx #(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick_c,
  output logic pre_tick_c
);

  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] TERM = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(BAUD_DIV - 2);

  logic [CW-1:0] cnt_q;

  assign tick_c     = en && (cnt_q == TERM);
  // Lets the parent register a pulse that lands exactly on the terminal cycle.
  assign pre_tick_c = en && (cnt_q == PRE);

  // Counts 0..BAUD_DIV-1 and wraps; clear wins over counting.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick_c ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_completa.sv
// UART transmitter: start bit, 8 data bits LSB-first, parity, stop bit.
// Ports: clk, reset (sync, active-high), start (request, sampled when idle),
//        d (byte captured on accept), tx (serial line, idle high),
//        busy (frame in flight), done (pulse in last stop-bit cycle).
module uart_tx_completa
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = 5208,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] d,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  logic [2:0]           state_q, state_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [2:0]           bit_q, bit_d;
  logic                 par_q, par_d;
  logic                 tx_d, busy_d, done_d;
  logic                 clr_c, tick_c, pre_tick_c;

  baud_tick_tx #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr_c),
    .en         (busy),
    .tick_c     (tick_c),
    .pre_tick_c (pre_tick_c)
  );

  // Next state and next registered outputs; tx is always computed one cycle ahead.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    par_d   = par_q;
    tx_d    = tx;
    busy_d  = busy;
    done_d  = 1'b0;
    clr_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d   = LINE_IDLE;
        busy_d = 1'b0;
        if (start) begin
          sh_d    = d;
          par_d   = parity_bit(d, PARITY_ODD);
          bit_d   = '0;
          clr_c   = 1'b1;
          state_d = ST_START;
          tx_d    = START_BIT;
          busy_d  = 1'b1;
        end
      end
      ST_START: begin
        if (tick_c) begin
          state_d = ST_DATA;
          tx_d    = sh_q[0];
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          sh_d = sh_q >> 1;
          if (bit_q == 3'(DATA_BITS - 1)) begin
            state_d = ST_PARITY;
            tx_d    = par_q;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = sh_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (tick_c) begin
          state_d = ST_STOP;
          tx_d    = LINE_IDLE;
        end
      end
      ST_STOP: begin
        done_d = pre_tick_c;
        if (tick_c) begin
          state_d = ST_IDLE;
          tx_d    = LINE_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = LINE_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      tx      <= LINE_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      tx      <= tx_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: doc/uart_tx_completa.md
Name: uart_tx_completa

Overview:
- 8N+parity UART transmitter; the transmit-side counterpart of the team's 11-bit-frame receiver (start, 8 data LSB-first, parity, stop).
- Accepts a byte through a start/busy handshake, serialises it at a fixed baud rate and reports completion with a one-cycle pulse.
- Sits between the system logic and the board TX pin. Its frame format is bit-compatible with the receiver, so data appears on the receiver's q and parity on its paridad.

Parameters:
- BAUD_DIV, 5208, clk cycles per bit (50 MHz / 9600 baud); legal range 2..65535.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  transmit request; sampled only while busy=0.
- d  input  8  byte to send; captured on the accepting edge.
- tx  output  1  serial line, registered; idle high.
- busy  output  1  high while a frame is in flight.
- done  output  1  one-cycle pulse in the last cycle of the stop bit.

Behaviour:
- Reset values: tx=1, busy=0, done=0, state=IDLE, bit counter=0, baud counter=0. Reset has priority over every other event.
- Reset mid-frame aborts the frame. tx returns to 1 on the next cycle and no done pulse is issued.
- FSM states: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
- IDLE:
  - When start=1 at edge k, latch d into the shift register and compute parity.
  - Even parity: p = ^d. Odd parity: p = ~^d.
  - Go to START.
  - start=0 keeps IDLE with tx=1.
- Latency: tx=0 and busy=1 from cycle k+1. The accepting edge itself produces no output change.
- Each bit is held for exactly BAUD_DIV cycles. The baud counter counts 0..BAUD_DIV-1; the terminal count is the bit-advance tick.
- START: tx=0 for one bit time, then DATA.
- DATA:
  - tx = shift register bit 0; shift right on each tick.
  - 3-bit counter selects d[0]..d[7].
  - Go to PARITY after 8 ticks.
- PARITY: tx=p for one bit time, then STOP.
- STOP:
  - tx=1 for one bit time.
  - done=1 during the final cycle (baud terminal count).
  - Next state is IDLE.
- busy is high for exactly 11*BAUD_DIV consecutive cycles per frame.
- start while busy=1 is ignored: no queuing, no effect on the current frame. d is don't-care while busy.
- Back-to-back: if start is held high, the next frame is accepted on the first IDLE cycle. This gives exactly one idle-high cycle between the stop bit and the next start bit.
- tx is driven only from flops; no combinational glitches on the pin.

Decomposition:
- Package uart_pkg:
  - tx state enum (IDLE, START, DATA, PARITY, STOP).
  - DATA_BITS=8, FRAME_BITS=11.
  - Line level constants LINE_IDLE=1, START_BIT=0.
- One sub-module, baud_tick_tx:
  - Baud counter with clear input (asserted on frame accept) and enable (busy).
  - Outputs a one-cycle tick at terminal count.
  - Width is $clog2(BAUD_DIV).
- FSM, shift register and parity live in the top module.

Test Plan:
- Reset check (BAUD_DIV=4): hold reset 3 cycles -> tx=1, busy=0, done=0. start=1 during reset -> no frame.
- Basic frame (BAUD_DIV=4, even parity): d=8'hA5, start pulse at edge k.
  - tx per 4-cycle bit = 0,1,0,1,0,0,1,0,1,0,1.
  - busy high cycles k+1..k+44.
  - done only at cycle k+44.
- Odd parity (PARITY_ODD=1): d=8'h07 -> parity bit 0. Same setup with PARITY_ODD=0 -> parity bit 1. Checked against the receiver model: q=8'h07.
- Busy lockout: start with d=8'h3C, then pulse start with d=8'hFF at bit 4 -> only 8'h3C is transmitted; exactly one done pulse.
- Back-to-back: start held high with d=8'h00 then 8'hFF -> two complete frames, one tx=1 gap cycle between them, two done pulses 45 cycles apart.
- Reset mid-frame: assert reset during DATA bit 3 -> tx=1 next cycle, busy=0, no done. A new start afterwards sends a clean full frame.
